// File: rtl/zx_ula_port.sv
// ULA port 0xFE: border/EAR/MIC latch, keyboard/tape read byte, Schmitt tape-in detector,
// saturating PCM mixer and beeper activity blinker. Define ULA_ISSUE2_EN for Issue-2 read leakage.
module zx_ula_port #(
    parameter int BORDER_W  = 3,
    parameter int PCM_W     = 16,
    parameter int TAPE_HI   = 4096,
    parameter int TAPE_LO   = -4096,
    parameter int EAR_AMP   = 16384,
    parameter int MIC_AMP   = 8192,
    parameter int TAPE_AMP  = 4096,
    parameter int BLINK_DIV = 7
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [15:0]             A,
    input  logic [7:0]              D,
    input  logic                    io_we,
    input  logic [4:0]              key_row,
    input  logic signed [PCM_W-1:0] pcm_inl,
    input  logic signed [PCM_W-1:0] pcm_inr,
    output logic [7:0]              ula_data,
    output logic [BORDER_W-1:0]     border,
    output logic                    ear,
    output logic                    mic,
    output logic                    tape_in,
    output logic signed [PCM_W-1:0] pcm_out,
    output logic                    beeper
);

    localparam logic signed [PCM_W:0] TAPE_HI_S = (PCM_W+1)'(TAPE_HI);
    localparam logic signed [PCM_W:0] TAPE_LO_S = (PCM_W+1)'(TAPE_LO);
    localparam logic [PCM_W+1:0]      EAR_A     = (PCM_W+2)'(EAR_AMP);
    localparam logic [PCM_W+1:0]      MIC_A     = (PCM_W+2)'(MIC_AMP);
    localparam logic [PCM_W+1:0]      TAPE_A    = (PCM_W+2)'(TAPE_AMP);
    localparam logic [PCM_W+1:0]      PCM_MAX   = (PCM_W+2)'(2**(PCM_W-1) - 1);

    logic [BORDER_W-1:0]     border_q, border_d;
    logic                    ear_q, ear_d;
    logic                    mic_q, mic_d;
    logic [PCM_W-1:0]        syn1_l_q, syn1_r_q, syn2_l_q, syn2_r_q;
    logic                    tape_q, tape_d;
    logic [PCM_W-1:0]        pcm_q, pcm_d;
    logic                    act_q, act_d;
    logic                    act_prev_q;
    logic [BLINK_DIV-1:0]    cnt_q, cnt_d;
    logic                    beeper_q, beeper_d;

    logic signed [PCM_W:0]   tape_sum;
    logic [PCM_W+1:0]        mix_sum;
    logic                    port_sel;
    logic                    bit6;
    logic                    act_rise;
    logic                    unused_ok;

    assign port_sel = ~A[0];
    assign unused_ok = ^{A[15:1], D};

    always_comb begin
        border_d = border_q;
        ear_d    = ear_q;
        mic_d    = mic_q;
        if (io_we && port_sel) begin
            border_d = D[BORDER_W-1:0];
            ear_d    = D[4];
            mic_d    = D[3];
        end
    end

    // Sign-extend both channels one bit so the stereo sum can never wrap.
    assign tape_sum = {syn2_l_q[PCM_W-1], syn2_l_q} + {syn2_r_q[PCM_W-1], syn2_r_q};

    always_comb begin
        tape_d = tape_q;
        if (tape_sum > TAPE_HI_S) begin
            tape_d = 1'b1;
        end else if (tape_sum < TAPE_LO_S) begin
            tape_d = 1'b0;
        end
    end

    assign mix_sum = (ear_q  ? EAR_A  : '0)
                   + (mic_q  ? MIC_A  : '0)
                   + (tape_q ? TAPE_A : '0);

    always_comb begin
        pcm_d = mix_sum[PCM_W-1:0];
        if (mix_sum > PCM_MAX) begin
            pcm_d = PCM_MAX[PCM_W-1:0];
        end
    end

    assign act_d    = ear_q ^ mic_q ^ tape_q;
    assign act_rise = act_q & ~act_prev_q;

    always_comb begin
        cnt_d    = cnt_q;
        beeper_d = beeper_q;
        if (act_rise) begin
            if (&cnt_q) begin
                cnt_d    = '0;
                beeper_d = ~beeper_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            border_q   <= '0;
            ear_q      <= 1'b0;
            mic_q      <= 1'b0;
            syn1_l_q   <= '0;
            syn1_r_q   <= '0;
            syn2_l_q   <= '0;
            syn2_r_q   <= '0;
            tape_q     <= 1'b0;
            pcm_q      <= '0;
            act_q      <= 1'b0;
            act_prev_q <= 1'b0;
            cnt_q      <= '0;
            beeper_q   <= 1'b0;
        end else begin
            border_q   <= border_d;
            ear_q      <= ear_d;
            mic_q      <= mic_d;
            syn1_l_q   <= pcm_inl;
            syn1_r_q   <= pcm_inr;
            syn2_l_q   <= syn1_l_q;
            syn2_r_q   <= syn1_r_q;
            tape_q     <= tape_d;
            pcm_q      <= pcm_d;
            act_q      <= act_d;
            act_prev_q <= act_q;
            cnt_q      <= cnt_d;
            beeper_q   <= beeper_d;
        end
    end

`ifdef ULA_ISSUE2_EN
    // Issue-2 boards leak the MIC output back onto the EAR read bit.
    assign bit6 = tape_q | mic_q;
`else
    assign bit6 = tape_q;
`endif

    assign ula_data = port_sel ? {1'b0, bit6, 1'b0, key_row} : 8'hFF;
    assign border   = border_q;
    assign ear      = ear_q;
    assign mic      = mic_q;
    assign tape_in  = tape_q;
    assign pcm_out  = pcm_q;
    assign beeper   = beeper_q;

endmodule
